// File: rtl/timer_pkg.sv
// Shared types and encodings for the programmable tick timer.
package timer_pkg;

  // Controller state: idle (stopped), running, one-shot expired
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counting direction encodings for cfg_up / up_reg
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Terminal behaviour encodings for cfg_oneshot / oneshot_reg
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: emits a strobe once every (div+1) enabled cycles.
module timer_prescaler #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] div,
  output logic          strobe
);

  localparam logic [PW-1:0] P_ONE = PW'(1);

  logic [PW-1:0] pcnt;

  // Strobe on the cycle the divider reaches its terminal value
  always_comb begin
    strobe = en && (pcnt == div);
  end

  // Divider count: cleared on request, wraps to zero after each strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= strobe ? '0 : pcnt + P_ONE;
    end
  end

endmodule

// File: rtl/prog_tick_timer.sv
// Programmable periodic / one-shot tick timer with up/down counting.
//
// Control interface (no valid/ready handshake): every input is a level
// sampled on the rising clock edge. start and stop are one-cycle requests,
// with stop taking priority when both are high. cfg_we is a one-cycle write
// strobe that is accepted only while busy=0; writes during RUN are dropped
// without any indication.
module prog_tick_timer
  import timer_pkg::*;
#(
  parameter int N              = 20,
  parameter int PW             = 8,
  parameter int DEFAULT_PERIOD = 100000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [N-1:0]  cfg_period,
  input  logic [PW-1:0] cfg_prescale,
  input  logic          cfg_up,
  input  logic          cfg_oneshot,
  input  logic          start,
  input  logic          stop,
  output logic          tic,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam logic [N-1:0] DEF_PERIOD = N'(DEFAULT_PERIOD);
  localparam logic [N-1:0] C_ONE      = N'(1);

  state_t        state_q;
  state_t        state_d;

  logic [N-1:0]  period_reg;
  logic [PW-1:0] prescale_reg;
  logic          up_reg;
  logic          oneshot_reg;

  logic          is_run;
  logic          go;
  logic          cnt_en;
  logic          pre_clr;
  logic          strobe;
  logic          terminal;
  logic          term_evt;
  logic [N-1:0]  reload_val;

  // Datapath qualifiers; a start or stop in RUN pre-empts that cycle's count step
  always_comb begin
    is_run     = (state_q == RUN);
    go         = start && !stop;
    cnt_en     = is_run && !start && !stop;
    pre_clr    = start || stop || !is_run;
    terminal   = (up_reg == DIR_UP) ? (count == period_reg) : (count == '0);
    term_evt   = cnt_en && strobe && terminal;
    reload_val = (up_reg == DIR_UP) ? '0 : period_reg;
  end

  timer_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (cnt_en),
    .clr    (pre_clr),
    .div    (prescale_reg),
    .strobe (strobe)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stop beats start; cfg_we returns an expired one-shot to IDLE
  always_comb begin
    state_d = state_q;
    if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end else if (cfg_we) begin
        state_d = IDLE;
      end
    end else if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (term_evt && (oneshot_reg == MODE_ONESHOT)) begin
            state_d = DONE;
          end
        end
        IDLE, DONE: begin
          if (cfg_we) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs, decoded straight from the state register
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Configuration registers, writable only outside RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      period_reg   <= DEF_PERIOD;
      prescale_reg <= '0;
      up_reg       <= DIR_UP;
      oneshot_reg  <= MODE_PERIODIC;
    end else if (cfg_we && !is_run) begin
      period_reg   <= cfg_period;
      prescale_reg <= cfg_prescale;
      up_reg       <= cfg_up;
      oneshot_reg  <= cfg_oneshot;
    end
  end

  // Main counter: reload on start, step on strobe, wrap or hold at terminal
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (go) begin
      count <= reload_val;
    end else if (cnt_en && strobe) begin
      if (terminal) begin
        if (oneshot_reg == MODE_PERIODIC) begin
          count <= reload_val;
        end
      end else if (up_reg == DIR_UP) begin
        count <= count + C_ONE;
      end else begin
        count <= count - C_ONE;
      end
    end
  end

  // Tick pulse, aligned with the edge that loads the wrapped count
  always_ff @(posedge clk) begin
    if (!rst) begin
      tic <= 1'b0;
    end else begin
      tic <= term_evt;
    end
  end

endmodule

// File: tb/tb_prog_tick_timer.sv
// Directed self-checking bench for prog_tick_timer.
module tb_prog_tick_timer;

  localparam int N  = 20;
  localparam int PW = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [N-1:0]  cfg_period;
  logic [PW-1:0] cfg_prescale;
  logic          cfg_up;
  logic          cfg_oneshot;
  logic          start;
  logic          stop;
  logic          tic;
  logic [N-1:0]  count;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  prog_tick_timer #(
    .N              (N),
    .PW             (PW),
    .DEFAULT_PERIOD (100000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_up       (cfg_up),
    .cfg_oneshot  (cfg_oneshot),
    .start        (start),
    .stop         (stop),
    .tic          (tic),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [N-1:0] exp_q[$];
  logic         exp_tic_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic cfg_write(input logic [N-1:0] p, input logic [PW-1:0] ps,
                           input logic up, input logic os);
    cfg_period   = p;
    cfg_prescale = ps;
    cfg_up       = up;
    cfg_oneshot  = os;
    cfg_we       = 1'b1;
    step();
    cfg_we       = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic tic_seen;
    rst = 1'b0; cfg_we = 1'b0; cfg_period = '0; cfg_prescale = '0;
    cfg_up = 1'b0; cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;

    // Reset defaults
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_tic",   tic,   0);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    rst = 1'b1;

    // Default config: up count toward 100000, no tick within 50 cycles
    pulse_start();
    chk("dflt_busy",  busy,  1);
    chk("dflt_count0", count, 0);
    tic_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      tic_seen = tic_seen | tic;
    end
    chk("dflt_count50", count, 50);
    chk("dflt_no_tic", tic_seen, 0);
    pulse_stop();
    chk("dflt_stop_count", count, 50);
    chk("dflt_stop_busy",  busy,  0);

    // Periodic up, period 4, with an ignored cfg write during RUN
    cfg_write(20'd4, 8'd0, 1'b1, 1'b0);
    pulse_start();
    chk("per_start_count", count, 0);
    chk("per_start_tic",   tic,   0);
    for (int r = 0; r < 2; r++) begin
      for (int v = 1; v <= 4; v++) begin
        exp_q.push_back(N'(v));
        exp_tic_q.push_back(1'b0);
      end
      exp_q.push_back('0);
      exp_tic_q.push_back(1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        cfg_period = 20'd9; cfg_prescale = 8'd5; cfg_up = 1'b0; cfg_we = 1'b1;
      end
      step();
      cfg_we = 1'b0;
      chk("per_count", count, exp_q.pop_front());
      chk("per_tic",   tic,   exp_tic_q.pop_front());
    end

    // Restart while running, then stop at count 2
    step(); step();
    chk("rs_pre_count", count, 2);
    pulse_start();
    chk("rs_count", count, 0);
    chk("rs_busy",  busy,  1);
    step(); step();
    pulse_stop();
    chk("stop_count", count, 2);
    chk("stop_busy",  busy,  0);
    step(); step(); step();
    chk("stop_frozen", count, 2);

    // start and stop together from IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy",  busy,  0);
    chk("ss_count", count, 2);

    // Prescaled: period 4, prescale 2 -> step every 3 cycles, tick every 15
    cfg_write(20'd4, 8'd2, 1'b1, 1'b0);
    pulse_start();
    chk("ps_count0", count, 0);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk("ps_count", count, (k / 3) % 5);
      chk("ps_tic",   tic,   (k % 15 == 0) ? 1 : 0);
    end
    pulse_stop();

    // One-shot down, period 3: 3,2,1,0 then single tick into DONE
    cfg_write(20'd3, 8'd0, 1'b0, 1'b1);
    pulse_start();
    chk("os_count3", count, 3);
    for (int v = 2; v >= 0; v--) begin
      step();
      chk("os_count", count, v);
      chk("os_tic",   tic,   0);
      chk("os_busy",  busy,  1);
    end
    step();
    chk("os_term_count", count, 0);
    chk("os_term_tic",   tic,   1);
    chk("os_term_done",  done,  1);
    chk("os_term_busy",  busy,  0);
    tic_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      tic_seen = tic_seen | tic;
    end
    chk("os_hold_count", count, 0);
    chk("os_hold_done",  done,  1);
    chk("os_hold_tic",   tic_seen, 0);
    cfg_write(20'd3, 8'd0, 1'b0, 1'b1);
    chk("os_clr_done", done, 0);
    chk("os_clr_busy", busy, 0);

    // period 0: tick on every strobe, count stays 0
    cfg_write(20'd0, 8'd0, 1'b1, 1'b0);
    pulse_start();
    chk("p0_start_tic", tic, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("p0_count", count, 0);
      chk("p0_tic",   tic,   1);
    end
    pulse_stop();
    chk("p0_stop_tic",  tic,  0);
    chk("p0_stop_busy", busy, 0);

    // Mid-run reset restores defaults including period_reg
    cfg_write(20'd4, 8'd0, 1'b1, 1'b0);
    pulse_start();
    step(); step(); step();
    chk("mr_pre_count", count, 3);
    rst = 1'b0;
    step();
    chk("mr_count", count, 0);
    chk("mr_tic",   tic,   0);
    chk("mr_busy",  busy,  0);
    chk("mr_done",  done,  0);
    rst = 1'b1;
    pulse_start();
    for (int i = 0; i < 5; i++) step();
    chk("mr_dflt_count", count, 5);
    chk("mr_dflt_tic",   tic,   0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
